reaction_timer: RTL

REACTION_TIMER -- requirements
Module: reaction_timer

---
 rtl/reaction_timer_pkg.sv | 21 ++
 rtl/reaction_timer_bcd_digit.sv | 32 +++
 rtl/reaction_timer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/reaction_timer_pkg.sv
// Shared definitions for the reaction timer.
//   state_t          : FSM state encoding (2 bits)
//   BCD_MAX          : largest displayable count, packed BCD 9999
//   DIGIT_MAX        : largest value of one decade digit
//   DEFAULT_CLK_HZ   : default input clock frequency
//   DEFAULT_TICK_HZ  : default count-increment rate (1 ms)
package reaction_timer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    OVERFLOW = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [15:0] BCD_MAX         = 16'h9999;
  localparam logic [3:0]  DIGIT_MAX       = 4'd9;
  localparam int          DEFAULT_CLK_HZ  = 50000000;
  localparam int          DEFAULT_TICK_HZ = 1000;

endpackage

// File: rtl/reaction_timer_bcd_digit.sv
// One decade (0..9) counter used as a digit of the reaction timer display.
// Ports:
//   clock  : system clock
//   reset  : asynchronous, active-high reset (q -> 0)
//   inc    : advance by one this cycle
//   clr    : synchronous zero, takes priority over inc
//   q      : current digit value
//   carry  : high when an increment wraps 9 -> 0 (feeds the next digit's inc)
module bcd_digit
  import reaction_timer_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] q,
  output logic       carry
);

  assign carry = inc && (q == DIGIT_MAX);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= 4'd0;
    end else if (clr) begin
      q <= 4'd0;
    end else if (inc) begin
      q <= (q == DIGIT_MAX) ? 4'd0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/reaction_timer.sv
// Reaction timer: counts elapsed ticks in 4-digit BCD while run is high,
// saturating at 9999, and remembers the best (lowest) non-overflowed result.
// Ports:
//   clock      : system clock
//   reset      : asynchronous, active-high reset
//   run        : count enable, asynchronous to clock (synchronized here)
//   clear      : synchronous single-cycle request to zero the current result
//   bcd        : current/held time, packed BCD, [15:12] = thousands
//   busy       : high in COUNTING or OVERFLOW
//   valid      : high in DONE
//   overflow   : count saturated at 9999
//   best       : lowest non-overflowed result since reset, packed BCD
//   best_valid : best holds a real result
module reaction_timer
  import reaction_timer_pkg::*;
#(
  parameter int CLK_HZ  = DEFAULT_CLK_HZ,
  parameter int TICK_HZ = DEFAULT_TICK_HZ
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        clear,
  output logic [15:0] bcd,
  output logic        busy,
  output logic        valid,
  output logic        overflow,
  output logic [15:0] best,
  output logic        best_valid
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);

  state_t          state;
  state_t          state_next;
  logic            run_meta;
  logic            run_s;
  logic            run_d;
  logic            rise;
  logic            fall;
  logic [PW-1:0]   presc;
  logic            tick;
  logic            start;
  logic            inc;
  logic            saturate;
  logic            finish;
  logic            carry0;
  logic            carry1;
  logic            carry2;
  logic            unused_carry3;

  // Synchronizer and registered edge detect; the registered edges add the
  // detect stage that makes run -> busy/valid exactly 4 cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_meta <= 1'b0;
      run_s    <= 1'b0;
      run_d    <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      run_meta <= run;
      run_s    <= run_meta;
      run_d    <= run_s;
      rise     <= run_s & ~run_d;
      fall     <= ~run_s & run_d;
    end
  end

  assign tick = (presc == PW'(DIV - 1));

  // Next-state and control decode; clear overrides everything, which also
  // discards a rise arriving in the same cycle.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    inc        = 1'b0;
    saturate   = 1'b0;
    finish     = 1'b0;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_next = COUNTING;
            start      = 1'b1;
          end
        end
        COUNTING: begin
          if (fall) begin
            state_next = DONE;
            finish     = 1'b1;
          end else if (tick) begin
            if (bcd == BCD_MAX) begin
              state_next = OVERFLOW;
              saturate   = 1'b1;
            end else begin
              inc = 1'b1;
            end
          end
        end
        OVERFLOW: begin
          if (fall) begin
            state_next = DONE;
          end
        end
        DONE: begin
          if (rise) begin
            state_next = COUNTING;
            start      = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Prescaler: zeroed on entry so the first tick lands DIV cycles later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (start || clear) begin
      presc <= '0;
    end else if (state == COUNTING) begin
      presc <= tick ? '0 : presc + PW'(1);
    end
  end

  // Overflow flag and best-result tracking
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      best       <= BCD_MAX;
      best_valid <= 1'b0;
    end else begin
      if (start || clear) begin
        overflow <= 1'b0;
      end else if (saturate) begin
        overflow <= 1'b1;
      end
      // Packed BCD orders the same as its decimal value, so a plain
      // unsigned compare picks the lower time.
      if (finish && (!best_valid || (bcd < best))) begin
        best       <= bcd;
        best_valid <= 1'b1;
      end
    end
  end

  bcd_digit u_digit0 (
    .clock (clock),
    .reset (reset),
    .inc   (inc),
    .clr   (start | clear),
    .q     (bcd[3:0]),
    .carry (carry0)
  );

  bcd_digit u_digit1 (
    .clock (clock),
    .reset (reset),
    .inc   (carry0),
    .clr   (start | clear),
    .q     (bcd[7:4]),
    .carry (carry1)
  );

  bcd_digit u_digit2 (
    .clock (clock),
    .reset (reset),
    .inc   (carry1),
    .clr   (start | clear),
    .q     (bcd[11:8]),
    .carry (carry2)
  );

  // Saturation is caught before the increment, so this carry never fires.
  bcd_digit u_digit3 (
    .clock (clock),
    .reset (reset),
    .inc   (carry2),
    .clr   (start | clear),
    .q     (bcd[15:12]),
    .carry (unused_carry3)
  );

  assign busy  = (state == COUNTING) || (state == OVERFLOW);
  assign valid = (state == DONE);

endmodule
